// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the serial add/sub arbiter.
// Optional build macro used by the top: ADDSUB_SEQ_SAT_EN (signed saturation).
package addsub_seq_pkg;

    // Arithmetic slice width in bits
    localparam int NIBBLE_W = 4;

    // Requester identifiers as carried on rsp_id
    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/addsub_seq_arbiter_slice.sv
// Combinational 4-bit ripple adder slice. The carry into the top bit (c3) is
// exported so the caller can form signed overflow as cout ^ c3.
module nibble_addsub_slice
    import addsub_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W:0]   full_sum;
    logic [NIBBLE_W-1:0] low_sum;

    // Full nibble add gives sum and carry out of the top bit
    assign full_sum = {1'b0, x} + {1'b0, y} + {{NIBBLE_W{1'b0}}, cin};

    // Add of the lower bits alone gives the carry into the top bit
    assign low_sum  = {1'b0, x[NIBBLE_W-2:0]} + {1'b0, y[NIBBLE_W-2:0]}
                    + {{(NIBBLE_W-1){1'b0}}, cin};

    assign sum  = full_sum[NIBBLE_W-1:0];
    assign cout = full_sum[NIBBLE_W];
    assign c3   = low_sum[NIBBLE_W-1];

endmodule

// File: rtl/addsub_seq_arbiter.sv
// Two-requester round-robin front end for a single shared 4-bit add/sub slice.
// Operations of W = 4*NIBBLES bits are computed serially, LSB nibble first.
// Build macro ADDSUB_SEQ_SAT_EN: when defined, an overflowing result is
// replaced by the signed saturation value on the way into rsp_sum.
//
// Handshake: reqN_ready is combinational and only high in IDLE for the
// granted requester with reqN_valid high; a transfer happens on a rising edge
// where valid && ready. A requester that is not granted keeps valid high and
// its operands stable. Responses are a single-cycle rsp_valid pulse with no
// backpressure; rsp_* stay stable until the next response.
module addsub_seq_arbiter
    import addsub_seq_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_sub,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_sub,

    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         rsp_ovf,
    output logic         busy,
    output state_e       dbg_state
);

    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e             state_q,      state_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   nib_cnt_q,    nib_cnt_d;
    logic               carry_q,      carry_d;
    logic [W-1:0]       a_q,          a_d;
    logic [W-1:0]       b_q,          b_d;
    logic               sub_q,        sub_d;
    logic               id_q,         id_d;
    logic [W-1:0]       acc_q,        acc_d;
    logic               rsp_valid_q,  rsp_valid_d;
    logic               rsp_id_q,     rsp_id_d;
    logic [W-1:0]       rsp_sum_q,    rsp_sum_d;
    logic               rsp_cout_q,   rsp_cout_d;
    logic               rsp_ovf_q,    rsp_ovf_d;

    logic               grant;
    logic [NIBBLE_W-1:0] slice_x, slice_y, slice_sum;
    logic               slice_cout, slice_c3;
    logic               last_nib;
    logic [W-1:0]       acc_shift;
    logic [W-1:0]       final_sum;

    // Operand registers shift right each RUN cycle, so the slice always sees bit 0 up
    assign slice_x = a_q[NIBBLE_W-1:0];
    assign slice_y = b_q[NIBBLE_W-1:0] ^ {NIBBLE_W{sub_q}};

    nibble_addsub_slice u_slice (
        .x    (slice_x),
        .y    (slice_y),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    assign last_nib = (nib_cnt_q == CNT_W'(NIBBLES - 1));

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        grant = ID_REQ0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = ID_REQ1;
        end
        req0_ready = (state_q == IDLE) && req0_valid && (grant == ID_REQ0);
        req1_ready = (state_q == IDLE) && req1_valid && (grant == ID_REQ1);
    end

    // Result assembly: new nibble enters at the top of the accumulator
    always_comb begin
        acc_shift = acc_q >> NIBBLE_W;
        final_sum = acc_shift;
        final_sum[W-1 -: NIBBLE_W] = slice_sum;
    end

    // Next-state and datapath update for the accept / serial run / respond sequence
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        nib_cnt_d    = nib_cnt_q;
        carry_d      = carry_q;
        a_d          = a_q;
        b_d          = b_q;
        sub_d        = sub_q;
        id_d         = id_q;
        acc_d        = acc_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_ovf_d    = rsp_ovf_q;

        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    a_d          = (grant == ID_REQ1) ? req1_a   : req0_a;
                    b_d          = (grant == ID_REQ1) ? req1_b   : req0_b;
                    sub_d        = (grant == ID_REQ1) ? req1_sub : req0_sub;
                    carry_d      = (grant == ID_REQ1) ? req1_sub : req0_sub;
                    id_d         = grant;
                    last_grant_d = grant;
                    nib_cnt_d    = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                a_d       = a_q >> NIBBLE_W;
                b_d       = b_q >> NIBBLE_W;
                acc_d     = final_sum;
                carry_d   = slice_cout;
                nib_cnt_d = nib_cnt_q + 1'b1;
                if (last_nib) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_cout_d  = slice_cout;
                    rsp_ovf_d   = slice_cout ^ slice_c3;
`ifdef ADDSUB_SEQ_SAT_EN
                    if (slice_cout ^ slice_c3) begin
                        rsp_sum_d = final_sum[W-1] ? {1'b0, {(W-1){1'b1}}}
                                                   : {1'b1, {(W-1){1'b0}}};
                    end else begin
                        rsp_sum_d = final_sum;
                    end
`else
                    rsp_sum_d   = final_sum;
`endif
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_REQ1;
            nib_cnt_q    <= '0;
            carry_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sub_q        <= 1'b0;
            id_q         <= 1'b0;
            acc_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            nib_cnt_q    <= nib_cnt_d;
            carry_q      <= carry_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sub_q        <= sub_d;
            id_q         <= id_d;
            acc_q        <= acc_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_ovf_q    <= rsp_ovf_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule
